// File: rtl/tns_pkg.sv
// tns_pkg: TNS decoder weight tables, width helper and FSM state type
package tns_pkg;

    typedef enum logic [1:0] {IDLE, ACC, DONE} tns_state_t;

    // Group g carries one base-5 digit: A weighs 2*5^g, B and C weigh 5^g each.
    localparam logic [63:0] TNS_W_C [0:15] = '{
        64'd1, 64'd5, 64'd25, 64'd125, 64'd625, 64'd3125, 64'd15625, 64'd78125,
        64'd390625, 64'd1953125, 64'd9765625, 64'd48828125, 64'd244140625,
        64'd1220703125, 64'd6103515625, 64'd30517578125
    };
    localparam logic [63:0] TNS_W_B [0:15] = TNS_W_C;
    localparam logic [63:0] TNS_W_A [0:15] = '{
        64'd2, 64'd10, 64'd50, 64'd250, 64'd1250, 64'd6250, 64'd31250, 64'd156250,
        64'd781250, 64'd3906250, 64'd19531250, 64'd97656250, 64'd488281250,
        64'd2441406250, 64'd12207031250, 64'd61035156250
    };

    // All-ones codeword sums to 5^n - 1, so the minimum width is clog2(5^n).
    function automatic int tns_data_w(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 5;
        return $clog2(p);
    endfunction

endpackage

// File: rtl/tns_dec_seq_if.sv
// tns_dec_seq_if: codeword input and result output handshakes of the TNS decoder
//   in_valid/in_ready/code_in    codeword stream into the decoder
//   out_valid/out_ready/data_out result stream out of the decoder, ovf flags a too-narrow sum
//   master = codeword source / result sink, slave = decoder
interface tns_dec_seq_if #(
    parameter int NGROUP = 6,
    parameter int DATA_W = 14
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3*NGROUP-1:0]   code_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     data_out;
    logic                  ovf;

    modport master (output in_valid, code_in, out_ready, input in_ready, out_valid, data_out, ovf);
    modport slave  (input in_valid, code_in, out_ready, output in_ready, out_valid, data_out, ovf);
endinterface

// File: rtl/tns_group_term.sv
// tns_group_term: weighted term of one 3-bit group, lane G of the fold at base group grp
//   grp  in   base group index of the current fold step
//   abc  in   {A,B,C} bits of group grp+G
//   term out  A*W_A + B*W_B + C*W_C, modulo 2^AW
module tns_group_term
    import tns_pkg::*;
#(
    parameter int G  = 0,
    parameter int AW = 14
) (
    input  logic [3:0]    grp,
    input  logic [2:0]    abc,
    output logic [AW-1:0] term
);
    logic [3:0]    idx;
    logic [AW-1:0] wa, wb, wc;

    assign idx  = grp + 4'(G);
    assign wa   = AW'(TNS_W_A[idx]);
    assign wb   = AW'(TNS_W_B[idx]);
    assign wc   = AW'(TNS_W_C[idx]);
    assign term = (abc[2] ? wa : '0) + (abc[1] ? wb : '0) + (abc[0] ? wc : '0);
endmodule

// File: rtl/tns_dec_seq.sv
// tns_dec_seq: multi-cycle TNS codeword to binary decoder, GPC groups folded per cycle
//   clk    in  rising-edge clock
//   rst_n  in  synchronous reset, active low
//   bus    slave side of tns_dec_seq_if (codeword in, result out)
//   Options: TNS_DEC_SKID_EN adds a one-entry input holding register;
//            TNS_DEC_OVF_EN widens the accumulator by one bit and drives ovf from the carry.
module tns_dec_seq
    import tns_pkg::*;
#(
    parameter int NGROUP = 6,
    parameter int GPC    = 2,
    parameter int DATA_W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    tns_dec_seq_if.slave bus
);
    localparam int CW = 3 * NGROUP;
    localparam int SW = 3 * GPC;
`ifdef TNS_DEC_OVF_EN
    localparam int AW = DATA_W + 1;
`else
    localparam int AW = DATA_W;
`endif
    localparam logic [3:0] LAST = 4'(NGROUP - GPC);

    if (NGROUP < 1 || NGROUP > 16 || GPC < 1 || NGROUP % GPC != 0) begin : g_bad_cfg
        $error("tns_dec_seq: GPC must divide NGROUP and NGROUP must be 1..16");
    end
`ifndef TNS_DEC_OVF_EN
    // With the overflow flag a narrower result is allowed since the carry is reported.
    if (DATA_W < tns_data_w(NGROUP)) begin : g_bad_w
        $error("tns_dec_seq: DATA_W cannot hold the all-ones codeword sum");
    end
`endif

    tns_state_t      state;
    logic [CW-1:0]   sh;
    logic [AW-1:0]   acc, acc_nxt;
    logic [AW-1:0]   term [GPC];
    logic [3:0]      grp_cnt;
    logic [DATA_W-1:0] dout;
    logic            vld, ovf_q, ovf_n, rdy, start;
    logic [CW-1:0]   start_code;

    for (genvar i = 0; i < GPC; i++) begin : g_t
        tns_group_term #(.G(i), .AW(AW)) u_term (
            .grp  (grp_cnt),
            .abc  (sh[3*i +: 3]),
            .term (term[i])
        );
    end

    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < GPC; i++) acc_nxt = acc_nxt + term[i];
    end

`ifdef TNS_DEC_OVF_EN
    assign ovf_n = acc_nxt[DATA_W];
`else
    assign ovf_n = 1'b0;
`endif

`ifdef TNS_DEC_SKID_EN
    logic          hold_full;
    logic [CW-1:0] hold_code;

    // A new decode starts from IDLE or straight out of DONE on the output transfer,
    // taking the held codeword first, otherwise the one on the bus.
    assign rdy        = ~hold_full;
    assign start      = (state == IDLE || (state == DONE && bus.out_ready)) && (hold_full || bus.in_valid);
    assign start_code = hold_full ? hold_code : bus.code_in;

    always_ff @(posedge clk) begin
        if (!rst_n) hold_full <= 1'b0;
        else hold_full <= hold_full ? ~start : (bus.in_valid & ~start);
        if (bus.in_valid && !hold_full) hold_code <= bus.code_in;
    end
`else
    logic rdy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) rdy_q <= 1'b1;
        else rdy_q <= start ? 1'b0 : (state == DONE && bus.out_ready) ? 1'b1 : rdy_q;
    end

    assign rdy        = rdy_q;
    assign start      = rdy_q && bus.in_valid;
    assign start_code = bus.code_in;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh      <= '0;
            acc     <= '0;
            grp_cnt <= '0;
            vld     <= 1'b0;
            dout    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (start) begin
                state   <= ACC;
                sh      <= start_code;
                acc     <= '0;
                grp_cnt <= '0;
                ovf_q   <= 1'b0;
            end
            case (state)
                ACC: begin
                    acc     <= acc_nxt;
                    sh      <= sh >> SW;
                    grp_cnt <= grp_cnt + 4'(GPC);
                    if (grp_cnt == LAST) begin
                        state <= DONE;
                        vld   <= 1'b1;
                        dout  <= acc_nxt[DATA_W-1:0];
                        ovf_q <= ovf_n;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        vld <= 1'b0;
                        if (!start) state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.data_out  = dout;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_tns_dec_seq.sv
// tb_tns_dec_seq: directed checks of tns_dec_seq against a base-5 golden sum
module tb_tns_dec_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tns_dec_seq_if #(.NGROUP(6), .DATA_W(14)) b ();
    tns_dec_seq #(.NGROUP(6), .GPC(2), .DATA_W(14)) dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    localparam int GP [4] = '{1, 2, 3, 6};
    logic        sw_valid;
    logic [17:0] sw_code;
    logic [3:0]  sw_ov;
    logic [13:0] sw_do [4];

    for (genvar i = 0; i < 4; i++) begin : g_sw
        tns_dec_seq_if #(.NGROUP(6), .DATA_W(14)) s ();
        assign s.in_valid  = sw_valid;
        assign s.code_in   = sw_code;
        assign s.out_ready = 1'b1;
        assign sw_ov[i]    = s.out_valid;
        assign sw_do[i]    = s.data_out;
        tns_dec_seq #(.NGROUP(6), .GPC(GP[i]), .DATA_W(14)) u (.clk(clk), .rst_n(rst_n), .bus(s.slave));
    end

`ifdef TNS_DEC_OVF_EN
    tns_dec_seq_if #(.NGROUP(6), .DATA_W(13)) o ();
    tns_dec_seq #(.NGROUP(6), .GPC(2), .DATA_W(13)) dut_ovf (.clk(clk), .rst_n(rst_n), .bus(o.slave));
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] gold(input logic [17:0] c);
        logic [63:0] s, p;
        s = 0;
        p = 1;
        for (int g = 0; g < 6; g++) begin
            s = s + p * (2 * 64'(c[3*g+2]) + 64'(c[3*g+1]) + 64'(c[3*g]));
            p = p * 5;
        end
        return s;
    endfunction

    // lat = clock edges from the accept edge to the first edge that sees out_valid high
    task automatic send(input logic [17:0] c, output int lat, output logic [13:0] d, output logic ov);
        int n = 0;
        b.code_in  = c;
        b.in_valid = 1'b1;
        while (!b.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        b.in_valid = 1'b0;
        lat = 0;
        while (!b.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        lat++;
        d  = b.data_out;
        ov = b.ovf;
        if (b.out_ready) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, n, t1, t2, cnt, acc_n;
        int          first [4];
        logic [13:0] d, sd [4];
        logic        ov, seen, stable, rdy_seen;
        logic [17:0] c, c2;
        logic [17:0] sweep_codes [2];

        b.in_valid  = 1'b1;
        b.code_in   = '1;
        b.out_ready = 1'b1;
        sw_valid    = 1'b0;
        sw_code     = '0;
`ifdef TNS_DEC_OVF_EN
        o.in_valid  = 1'b0;
        o.code_in   = '0;
        o.out_ready = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_ready", b.in_ready, 1);
        chk("rst_out_valid", b.out_valid, 0);
        chk("rst_data", b.data_out, 0);
        chk("rst_ovf", b.ovf, 0);
        b.in_valid = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= b.out_valid;
        end
        chk("rst_no_accept", seen, 0);

        for (int k = 0; k < 18; k++) begin
            c = 18'd1 << k;
            send(c, lat, d, ov);
            chk($sformatf("bit%0d_data", k), d, gold(c));
            chk($sformatf("bit%0d_lat", k), lat, 4);
        end
        send(18'd1, lat, d, ov);
        chk("bit0_is_c01", d, 1);
        send(18'h20000, lat, d, ov);
        chk("bit17_is_a06", d, 6250);
        send('0, lat, d, ov);
        chk("zero", d, 0);
        send('1, lat, d, ov);
        chk("all_ones", d, 15624);
        chk("all_ones_ovf", ov, 0);

        for (int i = 0; i < 1000; i++) begin
            c = 18'($urandom);
            send(c, lat, d, ov);
            chk($sformatf("rand%0d", i), d, gold(c));
        end

        b.code_in  = 18'h2AAAA;
        b.in_valid = 1'b1;
        t1 = -1;
        t2 = -1;
        cnt = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (b.out_valid) begin
                cnt++;
                if (cnt == 2) t1 = t;
                if (cnt == 3) t2 = t;
            end
        end
        b.in_valid = 1'b0;
`ifdef TNS_DEC_SKID_EN
        chk("throughput", t2 - t1, 4);
`else
        chk("throughput", t2 - t1, 5);
`endif
        repeat (20) @(negedge clk);

        b.out_ready = 1'b0;
        c  = 18'h15555;
        c2 = 18'h3F0C3;
        send(c, lat, d, ov);
        chk("bp_data0", d, gold(c));
`ifdef TNS_DEC_SKID_EN
        b.code_in  = c2;
        b.in_valid = 1'b1;
`endif
        acc_n = 0;
        stable = 1'b1;
        rdy_seen = 1'b0;
        repeat (5) begin
            rdy_seen |= b.in_ready;
            if (b.in_valid && b.in_ready) acc_n++;
            @(negedge clk);
            stable &= (b.out_valid === 1'b1) && (b.data_out === d);
        end
        chk("bp_stable", stable, 1);
`ifdef TNS_DEC_SKID_EN
        chk("bp_skid_accepts", acc_n, 1);
        chk("bp_skid_full", b.in_ready, 0);
`else
        chk("bp_no_ready", rdy_seen, 0);
`endif
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        @(negedge clk);
`ifdef TNS_DEC_SKID_EN
        n = 0;
        while (!b.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_skid_held_data", b.data_out, gold(c2));
        @(negedge clk);
`endif
        repeat (3) @(negedge clk);

        b.code_in  = 18'h3FFFF;
        b.in_valid = 1'b1;
        @(negedge clk);
        b.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", b.in_ready, 1);
        chk("midrst_out_valid", b.out_valid, 0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= b.out_valid;
        end
        chk("midrst_no_output", seen, 0);
        send(18'h0A5C3, lat, d, ov);
        chk("midrst_next_data", d, gold(18'h0A5C3));

        sweep_codes[0] = '1;
        sweep_codes[1] = 18'h1B2D4;
        for (int s = 0; s < 2; s++) begin
            sw_code  = sweep_codes[s];
            sw_valid = 1'b1;
            @(negedge clk);
            sw_valid = 1'b0;
            first = '{0, 0, 0, 0};
            for (int t = 1; t <= 10; t++) begin
                for (int i = 0; i < 4; i++) begin
                    if (sw_ov[i] && first[i] == 0) begin
                        first[i] = t;
                        sd[i] = sw_do[i];
                    end
                end
                @(negedge clk);
            end
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("sweep_gpc%0d_lat", GP[i]), first[i], 6 / GP[i] + 1);
                chk($sformatf("sweep_gpc%0d_data", GP[i]), sd[i], gold(sweep_codes[s]));
            end
        end

`ifdef TNS_DEC_OVF_EN
        o.code_in  = '1;
        o.in_valid = 1'b1;
        @(negedge clk);
        o.in_valid = 1'b0;
        n = 0;
        while (!o.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ovf_set", o.ovf, 1);
        chk("ovf_data", o.data_out, 7432);
        @(negedge clk);
        o.code_in  = '0;
        o.in_valid = 1'b1;
        @(negedge clk);
        o.in_valid = 1'b0;
        n = 0;
        while (!o.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ovf_clear", o.ovf, 0);
        chk("ovf_zero_data", o.data_out, 0);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
